pwm_update_scheduler: RTL

PWM_UPDATE_SCHEDULER -- requirements
Module: pwm_update_scheduler

---
 rtl/pwm_update_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pwm_update_scheduler.sv
// pwm_update_scheduler
//   Queues PWM channel update commands in a small FIFO and issues them one at
//   a time to channels 0..3. Each update is held until the target channel
//   acknowledges it or a timeout expires.
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        synchronous active-high reset
//   i_cmd_data   command word: [31:28] channel, [27] write flag,
//                [23:16] duty, [14:0] final value
//   i_cmd_we     command strobe
//   o_cmd_full   FIFO holds DEPTH entries
//   o_duty       duty of the update in flight
//   o_final      final value of the update in flight
//   o_upd_valid  one-hot update valid, bit n = channel n
//   i_done       per-channel update acknowledge
//   o_busy       update in flight or FIFO non-empty
//   o_status     [31] overflow, [27:24] timeout flags ch3..ch0,
//                [20:16] FIFO count, [0] state (1 = WAIT_DONE)
module pwm_update_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_cmd_data,
  input  logic        i_cmd_we,
  output logic        o_cmd_full,
  output logic [7:0]  o_duty,
  output logic [14:0] o_final,
  output logic [3:0]  o_upd_valid,
  input  logic [3:0]  i_done,
  output logic        o_busy,
  output logic [31:0] o_status
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, WAIT_DONE = 1'b1} state_t;

  // FIFO entry: {channel[1:0], duty[7:0], final[14:0]}
  logic [24:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  state_t        state_reg, state_next;
  logic [7:0]    timer_reg, timer_next;
  logic [1:0]    ch_reg, ch_next;
  logic [3:0]    valid_reg, valid_next;
  logic [7:0]    duty_reg, duty_next;
  logic [14:0]   final_reg, final_next;
  logic [3:0]    to_flags_reg, to_flags_next;
  logic          ovf_reg, ovf_next;

  logic          push_req, clr_req, full, push, pop;
  logic [24:0]   head;
  logic [3:0]    head_onehot;
  logic          unused_bits;

  // Bits of the command word that carry no meaning here.
  assign unused_bits = ^{i_cmd_data[26:24], i_cmd_data[15]};

  // Valid write to channels 0..3 requests an enqueue; channel 15 with the
  // write flag is the status-clear command. Everything else is ignored.
  assign push_req = i_cmd_we & i_cmd_data[27] & (i_cmd_data[31:30] == 2'b00);
  assign clr_req  = i_cmd_we & i_cmd_data[27] & (i_cmd_data[31:28] == 4'hF);
  // Fullness is judged on the pre-edge count, so a same-edge pop never
  // makes room for a push on a full FIFO.
  assign full     = (count_reg == CW'(DEPTH));
  assign push     = push_req & ~full;
  assign pop      = (state_reg == IDLE) && (count_reg != '0);
  assign head     = fifo_mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign head_onehot[gi] = (head[24:23] == 2'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {i_cmd_data[29:28], i_cmd_data[23:16], i_cmd_data[14:0]};
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    ch_next       = ch_reg;
    valid_next    = valid_reg;
    duty_next     = duty_reg;
    final_next    = final_reg;
    to_flags_next = to_flags_reg;
    ovf_next      = ovf_reg;
    count_next    = count_reg;

    case (state_reg)
      IDLE: begin
        if (pop) begin
          duty_next  = head[22:15];
          final_next = head[14:0];
          ch_next    = head[24:23];
          valid_next = head_onehot;
          timer_next = '0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Acknowledge takes priority over a timeout in the same cycle.
        if (i_done[ch_reg]) begin
          valid_next = '0;
          state_next = IDLE;
        end else if (timer_reg == 8'(TIMEOUT)) begin
          valid_next             = '0;
          to_flags_next[ch_reg]  = 1'b1;
          state_next             = IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (push_req && full) begin
      ovf_next = 1'b1;
    end
    if (clr_req) begin
      ovf_next      = 1'b0;
      to_flags_next = '0;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      ch_reg       <= '0;
      valid_reg    <= '0;
      duty_reg     <= '0;
      final_reg    <= '0;
      to_flags_reg <= '0;
      ovf_reg      <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      ch_reg       <= ch_next;
      valid_reg    <= valid_next;
      duty_reg     <= duty_next;
      final_reg    <= final_next;
      to_flags_reg <= to_flags_next;
      ovf_reg      <= ovf_next;
      count_reg    <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  assign o_cmd_full  = full;
  assign o_duty      = duty_reg;
  assign o_final     = final_reg;
  assign o_upd_valid = valid_reg;
  assign o_busy      = (state_reg == WAIT_DONE) || (count_reg != '0);
  assign o_status    = {ovf_reg, 3'b000, to_flags_reg, 3'b000, 5'(count_reg),
                        15'd0, (state_reg == WAIT_DONE)};

endmodule
